// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Holds the FSM state encoding, frame field names, default widths, the
// default sync marker, and a helper that says which states accept bytes.
package imem_loader_pkg;

   localparam int unsigned ADDR_W_DEF    = 8;
   localparam int unsigned DATA_W_DEF    = 8;
   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

   // Loader states, 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_LEN   = 3'd2,
      ST_LOAD  = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_e;

   // Fields of one frame, in stream order
   typedef enum logic [1:0] {
      FLD_SYNC    = 2'd0,
      FLD_LEN     = 2'd1,
      FLD_PAYLOAD = 2'd2,
      FLD_CSUM    = 2'd3
   } frame_field_e;

   // States that consume stream bytes
   function automatic logic is_accepting(input state_e s);
      return (s == ST_SYNC) || (s == ST_LEN) || (s == ST_LOAD) || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Program loader: parses a framed byte stream (sync, length, payload,
// checksum) and writes each payload byte into the instruction memory while
// holding the CPU. The CPU is released only after a matching checksum.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle request to begin/restart loading
//   in_valid/in_data  stream byte input; in_ready says it is taken
//   wr_en/addr/data   instruction memory write port (registered, 1 cycle)
//   cpu_hold          high in every state except DONE
//   done / error      load finished with good / bad checksum
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned       ADDR_W    = ADDR_W_DEF,
   parameter int unsigned       DATA_W    = DATA_W_DEF,
   parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_BYTE_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   // One extra bit so a length byte of 0 can represent a full memory
   localparam int unsigned CNT_W = ADDR_W + 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic                in_ready_q, in_ready_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                cpu_hold_q, cpu_hold_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                accept_c;

   assign accept_c = in_valid && in_ready_q;

   // Next state, counters, checksum and write request
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      addr_d    = addr_q;
      sum_d     = sum_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      case (state_q)
         ST_IDLE: if (start) state_d = ST_SYNC;
         ST_SYNC: if (accept_c && (in_data == SYNC_BYTE)) state_d = ST_LEN;
         ST_LEN: begin
            if (accept_c) begin
               count_d = (in_data == '0) ? CNT_W'(1) << ADDR_W : CNT_W'(in_data);
               addr_d  = '0;
               sum_d   = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (accept_c) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = in_data;
               sum_d     = sum_q + in_data;
               addr_d    = addr_q + ADDR_W'(1);
               count_d   = count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) state_d = ST_CHECK;
            end
         end
         ST_CHECK: if (accept_c) state_d = (in_data == sum_q) ? ST_DONE : ST_ERR;
         ST_DONE:  if (start) state_d = ST_SYNC;
         ST_ERR:   if (start) state_d = ST_SYNC;
         default:  state_d = ST_IDLE;
      endcase

      // Status outputs are registered copies of the upcoming state
      in_ready_d = is_accepting(state_d);
      cpu_hold_d = (state_d != ST_DONE);
      done_d     = (state_d == ST_DONE);
      error_d    = (state_d == ST_ERR);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         addr_q     <= '0;
         sum_q      <= '0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         sum_q      <= sum_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader. Each table row is one clock:
// inputs driven, one posedge, then outputs compared 1 time unit later.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       cpu_hold;
   logic       done;
   logic       error;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   imem_loader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   typedef struct {
      logic       rst;
      logic       start;
      logic       vld;
      logic [7:0] data;
      logic       rdy;
      logic       wen;
      logic [7:0] waddr;
      logic [7:0] wdata;
      logic       hold;
      logic       dn;
      logic       err;
      logic       chkw;   // compare wr_addr/wr_data on this row
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int r, int s, int v, int d, int rdy, int wen,
                               int wa, int wd, int hold, int dn, int err, int chkw);
      vec_t x;
      x.rst = 1'(r);    x.start = 1'(s);  x.vld = 1'(v);   x.data = 8'(d);
      x.rdy = 1'(rdy);  x.wen = 1'(wen);  x.waddr = 8'(wa); x.wdata = 8'(wd);
      x.hold = 1'(hold); x.dn = 1'(dn);   x.err = 1'(err); x.chkw = 1'(chkw);
      return x;
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
      end
   endtask

   task automatic drive_tick(input logic r, input logic s, input logic v, input logic [7:0] d);
      rst = r; start = s; in_valid = v; in_data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

      // rst start vld data | rdy wen waddr wdata hold done err chkw
      // reset wins over start; IDLE ignores stream bytes
      tbl.push_back(mk(1,1,0,'h00, 0,0,'h00,'h00, 1,0,0,1));
      tbl.push_back(mk(0,0,1,'hA5, 0,0,0,0, 1,0,0,0));
      // nominal frame
      tbl.push_back(mk(0,1,0,'h00, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'hA5, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h03, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h11, 1,1,'h00,'h11, 1,0,0,1));
      tbl.push_back(mk(0,0,1,'h22, 1,1,'h01,'h22, 1,0,0,1));
      tbl.push_back(mk(0,0,1,'h33, 1,1,'h02,'h33, 1,0,0,1));
      tbl.push_back(mk(0,0,1,'h66, 0,0,0,0, 0,1,0,0));
      tbl.push_back(mk(0,0,1,'hA5, 0,0,0,0, 0,1,0,0));
      // garbage before sync
      tbl.push_back(mk(0,1,0,'h00, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'hFF, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h00, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'hA5, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h01, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h7E, 1,1,'h00,'h7E, 1,0,0,1));
      tbl.push_back(mk(0,0,1,'h7E, 0,0,0,0, 0,1,0,0));
      // bad checksum; start ignored mid-frame; ERR ignores bytes
      tbl.push_back(mk(0,1,0,'h00, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'hA5, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h02, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h10, 1,1,'h00,'h10, 1,0,0,1));
      tbl.push_back(mk(0,1,1,'h20, 1,1,'h01,'h20, 1,0,0,1));
      tbl.push_back(mk(0,0,1,'h31, 0,0,0,0, 1,0,1,0));
      tbl.push_back(mk(0,0,1,'hA5, 0,0,0,0, 1,0,1,0));
      tbl.push_back(mk(0,1,0,'h00, 1,0,0,0, 1,0,0,0));
      // gaps in the payload and before the checksum
      tbl.push_back(mk(0,0,1,'hA5, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h02, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,0,'h99, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h05, 1,1,'h00,'h05, 1,0,0,1));
      tbl.push_back(mk(0,0,0,'h99, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h07, 1,1,'h01,'h07, 1,0,0,1));
      tbl.push_back(mk(0,0,0,'h0C, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h0C, 0,0,0,0, 0,1,0,0));
      // reset after 2 of 4 payload bytes drops the pending write
      tbl.push_back(mk(0,1,0,'h00, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'hA5, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h04, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h01, 1,1,'h00,'h01, 1,0,0,1));
      tbl.push_back(mk(0,0,1,'h02, 1,1,'h01,'h02, 1,0,0,1));
      tbl.push_back(mk(1,0,1,'h03, 0,0,'h00,'h00, 1,0,0,1));
      // recovery frame
      tbl.push_back(mk(0,1,0,'h00, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'hA5, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h01, 1,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,0,1,'h09, 1,1,'h00,'h09, 1,0,0,1));
      tbl.push_back(mk(0,0,1,'h09, 0,0,0,0, 0,1,0,0));

      foreach (tbl[i]) begin
         drive_tick(tbl[i].rst, tbl[i].start, tbl[i].vld, tbl[i].data);
         check("in_ready", i, 32'(in_ready), 32'(tbl[i].rdy));
         check("wr_en",    i, 32'(wr_en),    32'(tbl[i].wen));
         check("cpu_hold", i, 32'(cpu_hold), 32'(tbl[i].hold));
         check("done",     i, 32'(done),     32'(tbl[i].dn));
         check("error",    i, 32'(error),    32'(tbl[i].err));
         if (tbl[i].chkw) begin
            check("wr_addr", i, 32'(wr_addr), 32'(tbl[i].waddr));
            check("wr_data", i, 32'(wr_data), 32'(tbl[i].wdata));
         end
      end

      // Full-length frame: length byte 0 means 256 payload bytes
      drive_tick(1'b0, 1'b1, 1'b0, 8'h00);
      drive_tick(1'b0, 1'b0, 1'b1, 8'hA5);
      drive_tick(1'b0, 1'b0, 1'b1, 8'h00);
      check("full_len_rdy", 0, 32'(in_ready), 32'd1);
      for (int i = 0; i < 256; i++) begin
         drive_tick(1'b0, 1'b0, 1'b1, 8'(i));
         check("full_wr_en",   i, 32'(wr_en),   32'd1);
         check("full_wr_addr", i, 32'(wr_addr), 32'(i));
         check("full_wr_data", i, 32'(wr_data), 32'(i));
         if (i < 255) check("full_no_done", i, 32'(done), 32'd0);
      end
      drive_tick(1'b0, 1'b0, 1'b1, 8'h80);
      check("full_done",  0, 32'(done),     32'd1);
      check("full_hold",  0, 32'(cpu_hold), 32'd0);
      check("full_error", 0, 32'(error),    32'd0);
      check("full_wr_en", 0, 32'(wr_en),    32'd0);
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
